// File: rtl/byte_assembler.sv
// byte_assembler: MSB-first serial-to-byte assembler with a single-word output buffer.
// Define PARITY_EN to expect a trailing even-parity bit per word and report mismatches on par_err.
module byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_en,
    input  logic       sync,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       overrun,
    output logic       par_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`ifdef PARITY_EN
    localparam int SRW = 8;
    localparam state_t AFTER_LAST = PAR;
`else
    localparam int SRW = 7;
    localparam state_t AFTER_LAST = IDLE;
`endif
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [SRW-1:0] sr_q, sr_d;
    logic [7:0] dout_q, dout_d, word;
    logic dv_q, dv_d, ovr_q, ovr_d, perr_q, perr_d;
    logic start, last, complete, perr;

    assign start = sin_en && sync;
    assign last = state_q == SHIFT && sin_en && !sync && cnt_q == 3'd7;
`ifdef PARITY_EN
    assign complete = state_q == PAR && sin_en && !sync;
    assign word = sr_q;
    assign perr = complete && ((^sr_q) != sin);
`else
    assign complete = last;
    assign word = {sr_q, sin};
    assign perr = 1'b0;
`endif

    // state and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    // next state: sync restarts from any state, 8th bit moves on, parity bit ends the word
    always_comb begin
        state_d = state_q;
        if (start)
            state_d = SHIFT;
        else if (last)
            state_d = AFTER_LAST;
        else if (complete)
            state_d = IDLE;
    end

    // assembly register, counter and single-word output buffer
    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        dout_d = dout_q;
        dv_d   = dv_q;
        ovr_d  = ovr_q;
        perr_d = perr;
        if (start) begin
            sr_d  = {{(SRW-1){1'b0}}, sin};
            cnt_d = 3'd1;
        end else if (state_q == SHIFT && sin_en) begin
            sr_d  = {sr_q[SRW-2:0], sin};
            cnt_d = cnt_q + 3'd1;
        end
        if (complete && (!dv_q || dout_ready)) begin
            dout_d = word;
            dv_d   = 1'b1;
        end else if (complete)
            ovr_d = 1'b1;
        else if (dout_ready)
            dv_d = 1'b0;
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign overrun    = ovr_q;
    assign par_err    = perr_q;
endmodule

// File: tb/tb_byte_assembler.sv
// tb_byte_assembler: directed scenarios plus randomized traffic against a bit-list reference model.
module tb_byte_assembler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b0, sin_en = 1'b0, sync = 1'b0, dout_ready = 1'b0;
    logic [7:0] dout;
    logic dout_valid, overrun, par_err;
    int checks = 0;
    int errors = 0;
    int vcnt = 0;

`ifdef PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    bit m_act;
    int m_n;
    logic [8:0] m_acc;
    logic [7:0] m_dout;
    bit m_valid, m_ovr, m_perr;

    byte_assembler dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_act = 0; m_n = 0; m_acc = '0;
        m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic e, input logic r);
        bit done;
        logic [7:0] w;
        done = 0;
        if (e && s) begin
            m_act = 1; m_acc = {8'b0, b}; m_n = 1;
        end else if (e && m_act) begin
            m_acc = {m_acc[7:0], b}; m_n++;
            if (m_n == NB) begin done = 1; m_act = 0; end
        end
        w = (NB == 9) ? m_acc[8:1] : m_acc[7:0];
        m_perr = done && NB == 9 && ((^w) != m_acc[0]);
        if (done) begin
            if (!m_valid || r) begin m_dout = w; m_valid = 1; end
            else m_ovr = 1;
        end else if (m_valid && r)
            m_valid = 0;
    endtask

    task automatic cycle(input logic s, input logic b, input logic e, input logic r);
        sync = s; sin = b; sin_en = e; dout_ready = r;
        model_step(s, b, e, r);
        @(posedge clk);
        #1;
        if (dout_valid === 1'b1) vcnt++;
    endtask

    task automatic do_reset();
        rst = 0; sync = 0; sin = 0; sin_en = 0; dout_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        vcnt = 0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int from, input int to, input bit gap, input logic r);
        for (int i = from; i <= to; i++) begin
            cycle(i == 0, w[7-i], 1'b1, r);
            if (gap && i < to) cycle(1'b1, 1'($urandom), 1'b0, r);
        end
    endtask

    task automatic finish_par(input logic [7:0] w, input bit bad, input logic r);
`ifdef PARITY_EN
        cycle(1'b0, (^w) ^ bad, 1'b1, r);
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", par_err); end
    endtask

    task automatic test_basic();
        do_reset();
        send_bits(8'hA5, 0, 6, 0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL a5_early_valid got %b exp 0", dout_valid); end
        send_bits(8'hA5, 7, 7, 0, 1'b1);
        finish_par(8'hA5, 0, 1'b1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL a5_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL a5_dout got %h exp a5", dout); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL a5_valid_clear got %b exp 0", dout_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL a5_dout_hold got %h exp a5", dout); end
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL a5_valid_cycles got %0d exp 1", vcnt); end
    endtask

    task automatic test_sin_en_toggle();
        do_reset();
        send_bits(8'hA5, 0, 7, 1, 1'b1);
        finish_par(8'hA5, 0, 1'b1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL toggle_valid got %b exp 1", dout_valid); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL toggle_dout got %h exp a5", dout); end
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL toggle_valid_cycles got %0d exp 1", vcnt); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_bits(8'h3C, 0, 7, 0, 1'b0);
        finish_par(8'h3C, 0, 1'b0);
        checks++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_first got %h/%b exp 3c/1", dout, dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
        send_bits(8'hC3, 0, 7, 0, 1'b0);
        finish_par(8'hC3, 0, 1'b0);
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL ovr_hold_dout got %h exp 3c", dout); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b exp 0", dout_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    endtask

    task automatic test_restart();
        do_reset();
        send_bits(8'hFF, 0, 4, 0, 1'b1);
        send_bits(8'h81, 0, 7, 0, 1'b1);
        finish_par(8'h81, 0, 1'b1);
        checks++; if (dout !== 8'h81 || dout_valid !== 1'b1) begin errors++; $display("FAIL restart_word got %h/%b exp 81/1", dout, dout_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL restart_words got %0d exp 1", vcnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got %b exp 0", overrun); end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        do_reset();
        send_bits(8'h0F, 0, 7, 0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (dout !== 8'h0F || dout_valid !== 1'b1) begin errors++; $display("FAIL par_0f_word got %h/%b exp 0f/1", dout, dout_valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_0f_err got %b exp 0", par_err); end
        send_bits(8'h07, 0, 7, 0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (dout !== 8'h07 || dout_valid !== 1'b1) begin errors++; $display("FAIL par_07_word got %h/%b exp 07/1", dout, dout_valid); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_07_err got %b exp 1", par_err); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_pulse_end got %b exp 0", par_err); end
    endtask
`endif

    task automatic test_reset_midword();
        do_reset();
        send_bits(8'h5A, 0, 7, 0, 1'b0);
        finish_par(8'h5A, 0, 1'b0);
        send_bits(8'hC3, 0, 7, 0, 1'b0);
        finish_par(8'hC3, 0, 1'b0);
        send_bits(8'hFF, 0, 3, 0, 1'b0);
        #3;
        rst = 0;
        model_reset();
        #1;
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL async_dout got %h exp 00", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", dout_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL async_overrun got %b exp 0", overrun); end
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'($urandom), 1'b1, 1'b1);
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL nosync_valid cycle %0d got %b exp 0", i, dout_valid); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 9) < 7, 1'($urandom));
            checks++; if (dout_valid !== m_valid) begin errors++; $display("FAIL rand_valid cycle %0d got %b exp %b", i, dout_valid, m_valid); end
            checks++; if (dout !== m_dout) begin errors++; $display("FAIL rand_dout cycle %0d got %h exp %h", i, dout, m_dout); end
            checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun cycle %0d got %b exp %b", i, overrun, m_ovr); end
            checks++; if (par_err !== m_perr) begin errors++; $display("FAIL rand_par_err cycle %0d got %b exp %b", i, par_err, m_perr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sin_en_toggle();
        test_overrun();
        test_restart();
`ifdef PARITY_EN
        test_parity();
`endif
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
